// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder over a preloadable word memory: FIXED/INCR/WRAP bursts,
// programmable first-beat latency, SLVERR/DECERR beats. Define AXI_RD_STALL_EN for LFSR rvalid gaps.
module axi_read_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    input  logic                         preload_we,
    input  logic [$clog2(MEM_WORDS)-1:0] preload_addr,
    input  logic [DATA_WIDTH-1:0]        preload_wdata,
    output logic [1:0]                   dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; once valid is
    // raised it stays high with payload stable until that transfer occurs.

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int WA    = ADDR_WIDTH - 3;
    localparam logic [WA-1:0] MEM_WORDS_W = WA'(MEM_WORDS);
    localparam logic [3:0]    LAT_M1      = 4'(LATENCY - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [1:0]    RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [1:0]            resp;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [WA-1:0]         start_q, start_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    beat_t                 nxt_beat;
    logic                  load;
    logic                  load_valid;
`ifdef AXI_RD_STALL_EN
    logic                  gap_q, gap_d;
    logic [7:0]            lfsr_q, lfsr_d;
`endif

    // Byte offsets inside a 64-bit word carry no information for full-width beats.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^s_axi_araddr[2:0];

    always_ff @(posedge clock) begin
        if (preload_we) begin
            mem[preload_addr] <= preload_wdata;
        end
    end

    function automatic beat_t compute_beat(input logic [WA-1:0] start, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input logic [7:0] k);
        beat_t         b;
        logic          wrap_ok;
        logic          bad_req;
        logic [WA-1:0] mask;
        logic [WA-1:0] addr;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        bad_req = (size != 3'd3) || (burst == 2'd3) || ((burst == 2'd2) && !wrap_ok);
        mask    = WA'(len);
        case (burst)
            2'd0:    addr = start;
            2'd2:    addr = (start & ~mask) | ((start + WA'(k)) & mask);
            default: addr = start + WA'(k);
        endcase
        b.last = (k == len);
        if (bad_req) begin
            b.resp = RESP_SLVERR;
            b.data = '0;
        end else if (addr >= MEM_WORDS_W) begin
            b.resp = RESP_DECERR;
            b.data = '0;
        end else begin
            b.resp = RESP_OKAY;
            b.data = mem[addr[IDX_W-1:0]];
        end
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        start_d    = start_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        nxt_beat   = '0;
        load       = 1'b0;
        load_valid = 1'b1;
`ifdef AXI_RD_STALL_EN
        gap_d      = gap_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    arready_d  = 1'b0;
                    start_d    = s_axi_araddr[ADDR_WIDTH-1:3];
                    len_d      = s_axi_arlen;
                    size_d     = s_axi_arsize;
                    burst_d    = s_axi_arburst;
                    beat_cnt_d = 8'd0;
                    wait_cnt_d = 4'd0;
                    if (LATENCY == 0) begin
                        // Zero latency: beat 0 is built straight from the AR payload.
                        nxt_beat = compute_beat(s_axi_araddr[ADDR_WIDTH-1:3], s_axi_arlen,
                                                s_axi_arsize, s_axi_arburst, 8'd0);
                        load     = 1'b1;
                        state_d  = S_BURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == LAT_M1) begin
                    nxt_beat = compute_beat(start_q, len_q, size_q, burst_q, 8'd0);
                    load     = 1'b1;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        nxt_beat   = compute_beat(start_q, len_q, size_q, burst_q,
                                                  beat_cnt_q + 8'd1);
                        load       = 1'b1;
`ifdef AXI_RD_STALL_EN
                        load_valid = !lfsr_q[0];
                        gap_d      = lfsr_q[0];
`endif
                    end
                end
`ifdef AXI_RD_STALL_EN
                else if (gap_q) begin
                    rvalid_d = 1'b1;
                    gap_d    = 1'b0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            rvalid_d = load_valid;
            rdata_d  = nxt_beat.data;
            rresp_d  = nxt_beat.resp;
            rlast_d  = nxt_beat.last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            start_q    <= '0;
            len_q      <= 8'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            beat_cnt_q <= 8'd0;
            wait_cnt_q <= 4'd0;
`ifdef AXI_RD_STALL_EN
            gap_q      <= 1'b0;
            lfsr_q     <= 8'hA5;
`endif
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef AXI_RD_STALL_EN
            gap_q      <= gap_d;
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomized and directed bench for axi_read_responder: expected beats come from a
// behavioural burst model over a shadow memory and are checked by an independent R monitor.
module tb_axi_read_responder;

    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int MEM_WORDS  = 4096;
    localparam int LATENCY    = 2;
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int BW         = DATA_WIDTH + 3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  s_axi_arvalid = 1'b0;
    logic                  s_axi_arready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr = '0;
    logic [7:0]            s_axi_arlen = 8'd0;
    logic [2:0]            s_axi_arsize = 3'd3;
    logic [1:0]            s_axi_arburst = 2'd1;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready = 1'b1;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  preload_we = 1'b0;
    logic [IDX_W-1:0]      preload_addr = '0;
    logic [DATA_WIDTH-1:0] preload_wdata = '0;
    logic [1:0]            dbg_state_o;

    logic [DATA_WIDTH-1:0] model_mem [MEM_WORDS];
    logic [BW-1:0]         exp_q [$];
    int                    n_cmp = 0;
    int                    n_bad = 0;
    int                    hs_count = 0;
    int                    rdy_mode = 0;
    logic [2:0]            pat_idx = 3'd0;
    logic [7:0]            rdy_pat = 8'b1011_0010;

    axi_read_responder #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .preload_we(preload_we), .preload_addr(preload_addr), .preload_wdata(preload_wdata),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and safety timeout
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: beat k of a burst, from the burst rules in plain arithmetic
    function automatic logic [BW-1:0] exp_beat(input logic [63:0] addr, input int len,
                                               input int size, input int burst, input int k);
        longint unsigned start, w, l;
        bit err, last;
        start = addr >> 3;
        l     = longint'(len) + 1;
        err   = (size != 3) || (burst == 3) ||
                (burst == 2 && !(l == 2 || l == 4 || l == 8 || l == 16));
        case (burst)
            0:       w = start;
            2:       w = (start / l) * l + ((start % l) + longint'(k)) % l;
            default: w = start + longint'(k);
        endcase
        last = (k == len);
        if (err) return {last, 2'b10, 64'h0};
        if (w >= MEM_WORDS) return {last, 2'b11, 64'h0};
        return {last, 2'b00, model_mem[w]};
    endfunction

    // rready driver: 0 = always ready, 1 = fixed pattern over valid cycles, 2 = random
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: s_axi_rready = 1'b1;
            1: begin
                if (s_axi_rvalid) begin
                    s_axi_rready = rdy_pat[pat_idx];
                    pat_idx = pat_idx + 3'd1;
                end else begin
                    s_axi_rready = 1'b0;
                end
            end
            default: s_axi_rready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard
    logic          stall_prev = 1'b0;
    logic          post_last = 1'b0;
    logic [BW-1:0] held = '0;

    always @(negedge clock) begin
        logic [BW-1:0] e;
        if (reset) begin
            stall_prev = 1'b0;
            post_last  = 1'b0;
        end else begin
            if (post_last) begin
                check("rvalid_after_last", BW'(s_axi_rvalid), BW'(0));
                check("arready_after_last", BW'(s_axi_arready), BW'(1));
                post_last = 1'b0;
            end
            if (stall_prev) begin
                check("rvalid_held_on_stall", BW'(s_axi_rvalid), BW'(1));
                check("beat_stable_on_stall", {s_axi_rlast, s_axi_rresp, s_axi_rdata}, held);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h expected no beat",
                             {s_axi_rlast, s_axi_rresp, s_axi_rdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {s_axi_rlast, s_axi_rresp, s_axi_rdata}, e);
                    hs_count++;
                    if (s_axi_rlast) post_last = 1'b1;
                end
            end
            stall_prev = s_axi_rvalid && !s_axi_rready;
            held       = {s_axi_rlast, s_axi_rresp, s_axi_rdata};
        end
    end

    // Driver tasks (all start and end 1 time unit after a rising edge)
    task automatic preload(input int idx, input logic [DATA_WIDTH-1:0] val);
        preload_we     = 1'b1;
        preload_addr   = IDX_W'(idx);
        preload_wdata  = val;
        model_mem[idx] = val;
        @(posedge clock);
        #1;
        preload_we = 1'b0;
    endtask

    task automatic issue_ar(input logic [63:0] addr, input int len, input int size, input int burst);
        int   c;
        logic rdy;
        for (int k = 0; k <= len; k++) exp_q.push_back(exp_beat(addr, len, size, burst, k));
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = 3'(size);
        s_axi_arburst = 2'(burst);
        s_axi_arvalid = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            rdy = s_axi_arready;
        end while (!rdy && c < 50);
        check("ar_accepted", BW'(rdy), BW'(1));
        @(posedge clock);
        #1;
        s_axi_arvalid = 1'b0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!s_axi_rvalid && c < 40);
        check("first_rvalid_latency", BW'(c), BW'(LATENCY + 1));
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 600) begin
            @(posedge clock);
            g++;
        end
        check("burst_drained", BW'(exp_q.size()), BW'(0));
        if (exp_q.size() != 0) begin
            exp_q.delete();
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
        end
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic run_burst(input logic [63:0] addr, input int len, input int size, input int burst);
        issue_ar(addr, len, size, burst);
        wait_drain();
    endtask

    task automatic reset_mid_burst();
        int target;
        int g;
        rdy_mode = 0;
        target = hs_count + 3;
        issue_ar(64'h0, 7, 3, 1);
        g = 0;
        while (hs_count < target && g < 100) begin
            @(posedge clock);
            g++;
        end
        check("reached_third_handshake", BW'(hs_count), BW'(target));
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("rvalid_after_reset", BW'(s_axi_rvalid), BW'(0));
        check("rlast_after_reset", BW'(s_axi_rlast), BW'(0));
        check("arready_in_reset_cycle", BW'(s_axi_arready), BW'(0));
        @(negedge clock);
        check("arready_after_reset_release", BW'(s_axi_arready), BW'(1));
        @(posedge clock);
        #1;
        run_burst(64'h0, 7, 3, 1);
    endtask

    initial begin
        int wl[4];
        int r, burst, len, size;
        logic [63:0] addr;
        wl = '{1, 3, 7, 15};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_arready", BW'(s_axi_arready), BW'(0));
        check("reset_rvalid", BW'(s_axi_rvalid), BW'(0));
        check("reset_rlast", BW'(s_axi_rlast), BW'(0));
        check("reset_rresp", BW'(s_axi_rresp), BW'(0));
        check("reset_rdata", BW'(s_axi_rdata), BW'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < MEM_WORDS; i++) begin
            if (i < 16) preload(i, 64'h1111_0000_0000_0000 + 64'(i));
            else preload(i, {$urandom, $urandom});
        end
        @(negedge clock);
        check("idle_arready", BW'(s_axi_arready), BW'(1));
        @(posedge clock);
        #1;

        rdy_mode = 0;
        run_burst(64'h40, 7, 3, 1);                       // INCR words 8..15
        run_burst(64'h50, 7, 3, 2);                       // WRAP 10..15,8,9
        rdy_mode = 1;
        pat_idx  = 3'd0;
        run_burst(64'h0, 3, 3, 1);                        // backpressure pattern
        rdy_mode = 0;
        run_burst(64'h0, 3, 2, 1);                        // arsize=2 -> SLVERR
        run_burst(64'((MEM_WORDS - 2) * 8), 3, 3, 1);     // runs off the end -> DECERR
        reset_mid_burst();
        run_burst(64'h18, 3, 3, 0);                       // FIXED word 3
        run_burst(64'h20, 3, 3, 3);                       // reserved burst type
        run_burst(64'h20, 2, 3, 2);                       // WRAP with illegal length

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            burst = (r == 0) ? 3 : (r <= 3) ? 0 : (r <= 6) ? 1 : 2;
            len   = (burst == 2) ? wl[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
            size  = ($urandom_range(0, 9) == 0) ? 2 : 3;
            addr  = 64'($urandom_range(0, (MEM_WORDS + 4) * 8 - 1));
            run_burst(addr, len, size, burst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
